sa_result_collector: RTL and testbench

Back end of the 8x8 systolic matrix multiplier: the counterpart to the skewed input feeder. After the array finishes accumulating, it drains C row by row on N skewed lanes, mirroring the input skew. This block de-skews those lanes into a 64-entry result buffer, then streams C out in row-major order over a valid/ready handshake to the downstream consumer (result memory / host interface).

---
 rtl/sa_result_collector_if.sv | 29 ++
 rtl/sa_result_collector.sv | 88 ++++++++
 tb/tb_sa_result_collector.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/sa_result_collector_if.sv
// Result-drain bus of the systolic multiplier back end: skewed lane inputs,
// row-major valid/ready output stream and job status.
interface sa_result_collector_if #(
  parameter int N  = 8,
  parameter int DW = 20
);
  localparam int RW = $clog2(N);

  logic            start;
  logic [N*DW-1:0] lane_data;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [RW-1:0]   out_row;
  logic [RW-1:0]   out_col;
  logic            busy;
  logic            done;

  modport master (
    output start, lane_data, out_ready,
    input  out_data, out_valid, out_last, out_row, out_col, busy, done
  );

  modport slave (
    input  start, lane_data, out_ready,
    output out_data, out_valid, out_last, out_row, out_col, busy, done
  );
endinterface

// File: rtl/sa_result_collector.sv
// De-skews the N drain lanes of the systolic array into an N*N register buffer,
// then streams C row-major over valid/ready.
module sa_result_collector #(
  parameter int N  = 8,
  parameter int DW = 20
) (
  input  logic                clk,
  input  logic                rst_n,
  sa_result_collector_if.slave bus
);
  // N must be a power of two so the read index splits directly into row/col.
  localparam int RW = $clog2(N);
  localparam int IW = 2 * RW;
  localparam int KW = $clog2(2 * N - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(2 * N - 2);
  localparam logic [IW-1:0] IDX_LAST = IW'(N * N - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, STREAM} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [KW-1:0] r_k;
  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_buf [N*N];
  logic          r_done;
  logic          w_beat;
  logic          w_last;

  assign w_last = (r_idx == IDX_LAST);
  assign w_beat = (r_state == STREAM) && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (bus.start)     w_next = CAPTURE;
      CAPTURE: if (r_k == K_LAST) w_next = STREAM;
      STREAM:  if (w_beat && w_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= '0;
      r_idx  <= '0;
      r_done <= 1'b0;
      for (int unsigned i = 0; i < N * N; i++) r_buf[i] <= '0;
    end else begin
      r_done <= w_beat && w_last;
      case (r_state)
        IDLE: if (bus.start) r_k <= '0;
        CAPTURE: begin
          r_k   <= r_k + 1'b1;
          r_idx <= '0;
          // Lane r holds C[r][k-r] only while 0 <= k-r < N; other cycles are skew padding.
          for (int unsigned r = 0; r < N; r++) begin
            if ((r_k >= KW'(r)) && ((r_k - KW'(r)) < KW'(N)))
              r_buf[IW'(r * N) + IW'(r_k - KW'(r))] <= bus.lane_data[r*DW +: DW];
          end
        end
        STREAM: if (w_beat) r_idx <= r_idx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_row   = '0;
    bus.out_col   = '0;
    bus.out_last  = 1'b0;
    bus.busy      = (r_state != IDLE);
    bus.done      = r_done;
    if (r_state == STREAM) begin
      bus.out_valid = 1'b1;
      bus.out_data  = r_buf[r_idx];
      bus.out_row   = r_idx[IW-1:RW];
      bus.out_col   = r_idx[RW-1:0];
      bus.out_last  = w_last;
    end
  end
endmodule

// File: tb/tb_sa_result_collector.sv
// Self-checking bench for sa_result_collector: table of job scenarios plus
// reset-abort and back-to-back sequences, checked against a matrix model.
module tb_sa_result_collector;
  localparam int N  = 8;
  localparam int DW = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sa_result_collector_if #(.N(N), .DW(DW)) bus ();

  sa_result_collector #(.N(N), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    int mode;       // 0 pattern, 1 random, 2 lane-7 skew pattern
    int rmode;      // 0 ready=1, 1 ready 1,0,0,1, 2 random ready
    bit busy_start; // extra start pulses during capture and stream
    int exp_done;   // cycle of done pulse (0 = not fixed)
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_job(input int mode, input int rmode, input bit busy_start,
                         input int abort_at, input bit chain, input bit started,
                         input int exp_done);
    logic [DW-1:0] m [N][N];
    logic [DW-1:0] v;
    logic [DW-1:0] sd;
    logic [2:0]    sr, sc;
    logic          sl;
    bit            stalled;
    bit            rdy;
    int            c, cyc, beats, t;

    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        if (mode == 1)                m[r][j] = DW'($urandom);
        else if (mode == 2 && r == 7) m[r][j] = DW'(7 + j);
        else                          m[r][j] = DW'((r << 8) | j);
      end

    if (!started) begin
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    cyc = 1;

    for (int k = 0; k < 2 * N - 1; k++) begin
      for (int r = 0; r < N; r++) begin
        c = k - r;
        if (c >= 0 && c < N)          v = m[r][c];
        else if (mode == 1)           v = DW'($urandom);
        else if (mode == 2 && r == 7) v = 20'hABCDE;
        else                          v = 20'hFFFFF;
        bus.lane_data[r*DW +: DW] = v;
      end
      bus.start = busy_start && (k == 5);
      @(negedge clk);
      chk("capture_busy", bus.busy, 1);
      chk("capture_valid", bus.out_valid, 0);
      chk("capture_done", bus.done, 0);
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;

    beats = 0; stalled = 0; t = 0;
    sd = '0; sr = '0; sc = '0; sl = 0;
    while (beats < N * N && t < 2000) begin
      case (rmode)
        0:       rdy = 1'b1;
        1:       rdy = (t % 4 == 0) || (t % 4 == 3);
        default: rdy = 1'($urandom);
      endcase
      bus.out_ready = rdy;
      bus.start = busy_start && (beats == 30);
      @(negedge clk);
      chk("stream_valid", bus.out_valid, 1);
      chk("stream_done", bus.done, 0);
      if (stalled) begin
        chk("stall_data", bus.out_data, sd);
        chk("stall_row", bus.out_row, sr);
        chk("stall_col", bus.out_col, sc);
        chk("stall_last", bus.out_last, sl);
      end
      if (rdy) begin
        chk("beat_data", bus.out_data, m[beats / N][beats % N]);
        chk("beat_row", bus.out_row, beats / N);
        chk("beat_col", bus.out_col, beats % N);
        chk("beat_last", bus.out_last, beats == N * N - 1);
        beats++;
        stalled = 0;
      end else begin
        sd = bus.out_data; sr = bus.out_row; sc = bus.out_col; sl = bus.out_last;
        stalled = 1;
      end
      @(posedge clk); #1;
      cyc++; t++;
      if (abort_at != 0 && beats == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        chk("abort_data", bus.out_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_idle_busy", bus.busy, 0);
        chk("abort_no_done", bus.done, 0);
        bus.out_ready = 1'b1;
        return;
      end
    end
    chk("stream_beats", beats, N * N);

    bus.start = chain;
    @(negedge clk);
    chk("done_pulse", bus.done, 1);
    chk("done_busy", bus.busy, 0);
    chk("done_valid", bus.out_valid, 0);
    if (exp_done > 0) chk("done_cycle", cyc, exp_done);
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (!chain) begin
      @(negedge clk);
      chk("done_once", bus.done, 0);
      chk("idle_busy", bus.busy, 0);
    end
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 0, 1'b0, 80};
    vecs[1] = '{0, 1, 1'b0, 0};
    vecs[2] = '{2, 0, 1'b0, 80};
    vecs[3] = '{0, 0, 1'b1, 80};
    vecs[4] = '{1, 2, 1'b0, 0};
    vecs[5] = '{1, 0, 1'b1, 80};

    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    bus.lane_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_row", bus.out_row, 0);
    chk("rst_col", bus.out_col, 0);
    chk("rst_last", bus.out_last, 0);

    foreach (vecs[i])
      run_job(vecs[i].mode, vecs[i].rmode, vecs[i].busy_start, 0, 1'b0, 1'b0, vecs[i].exp_done);

    // Reset after 20 accepted beats, then a fresh random job.
    run_job(1, 0, 1'b0, 20, 1'b0, 1'b0, 0);
    run_job(1, 0, 1'b0, 0, 1'b0, 1'b0, 80);

    // Back-to-back: second start lands in the done cycle.
    run_job(1, 0, 1'b0, 0, 1'b1, 1'b0, 80);
    run_job(1, 2, 1'b0, 0, 1'b0, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
